// File: rtl/vga_pkg.sv
// Shared geometry defaults and types for the VGA sprite overlay.
package vga_pkg;

   localparam int unsigned H_ACTIVE_DEF = 640;
   localparam int unsigned V_ACTIVE_DEF = 480;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef enum logic [1:0] {RIGHT, LEFT, DOWN, UP} dir_t;

endpackage

// File: rtl/vga_sprite_motion.sv
// Sprite position: end-of-frame tick detector plus one bounce FSM per axis.
// Position moves only on the last active pixel of a frame, so it never changes mid-frame.
module vga_sprite_motion
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned BOX_SIZE = 32,
   parameter int unsigned STEP     = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] x_pos_i,
   input  logic [11:0] y_pos_i,
   input  logic        video_active_i,
   input  logic        enable_i,
   output logic [11:0] box_x_o,
   output logic [11:0] box_y_o
);

   localparam logic [11:0] XMax   = 12'(H_ACTIVE - BOX_SIZE);
   localparam logic [11:0] YMax   = 12'(V_ACTIVE - BOX_SIZE);
   localparam logic [11:0] Step   = 12'(STEP);
   localparam logic [11:0] XLast  = 12'(H_ACTIVE - 1);
   localparam logic [11:0] YLast  = 12'(V_ACTIVE - 1);

   logic        frame_tick;
   logic [11:0] box_x_q, box_y_q;
   dir_t        dir_x_q, dir_y_q;

   assign frame_tick = video_active_i && (x_pos_i == XLast) && (y_pos_i == YLast);

   // Compares are done one bit wider so box + STEP cannot wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         box_x_q <= '0;
         box_y_q <= '0;
         dir_x_q <= RIGHT;
         dir_y_q <= DOWN;
      end else if (frame_tick && enable_i) begin
         unique case (dir_x_q)
            RIGHT: begin
               if (({1'b0, box_x_q} + {1'b0, Step}) >= {1'b0, XMax}) begin
                  box_x_q <= XMax;
                  dir_x_q <= LEFT;
               end else begin
                  box_x_q <= box_x_q + Step;
               end
            end
            LEFT: begin
               if (box_x_q <= Step) begin
                  box_x_q <= '0;
                  dir_x_q <= RIGHT;
               end else begin
                  box_x_q <= box_x_q - Step;
               end
            end
            default: dir_x_q <= RIGHT;
         endcase

         unique case (dir_y_q)
            DOWN: begin
               if (({1'b0, box_y_q} + {1'b0, Step}) >= {1'b0, YMax}) begin
                  box_y_q <= YMax;
                  dir_y_q <= UP;
               end else begin
                  box_y_q <= box_y_q + Step;
               end
            end
            UP: begin
               if (box_y_q <= Step) begin
                  box_y_q <= '0;
                  dir_y_q <= DOWN;
               end else begin
                  box_y_q <= box_y_q - Step;
               end
            end
            default: dir_y_q <= DOWN;
         endcase
      end
   end

   assign box_x_o = box_x_q;
   assign box_y_o = box_y_q;

endmodule

// File: rtl/vga_sprite_overlay.sv
// Bouncing-box overlay on a VGA pixel stream: hit compare, colour mux, 1-cycle output delay.
// Define VGA_SPRITE_OVERLAY_BORDER_EN to draw only a 2-pixel outline instead of a solid box.
module vga_sprite_overlay
   import vga_pkg::*;
#(
   parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
   parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
   parameter int unsigned BOX_SIZE = 32,
   parameter int unsigned STEP     = 2,
   parameter logic [23:0] BOX_RGB  = 24'hFF0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] x_pos,
   input  logic [11:0] y_pos,
   input  logic        video_active,
   input  logic        h_pulse_in,
   input  logic        v_pulse_in,
   input  logic [7:0]  rgb_r_in,
   input  logic [7:0]  rgb_g_in,
   input  logic [7:0]  rgb_b_in,
   input  logic        enable,
   output logic [7:0]  rgb_r,
   output logic [7:0]  rgb_g,
   output logic [7:0]  rgb_b,
   output logic        h_pulse,
   output logic        v_pulse,
   output logic        video_active_out
);

   localparam logic [11:0] BoxSz = 12'(BOX_SIZE);

   logic [11:0] box_x, box_y;
   logic [11:0] dx, dy;
   logic        in_x, in_y, draw;
   rgb_t        rgb_d, rgb_q;
   logic        h_q, v_q, va_q;

   vga_sprite_motion #(
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE),
      .BOX_SIZE (BOX_SIZE),
      .STEP     (STEP)
   ) u_motion (
      .clk            (clk),
      .rst            (rst),
      .x_pos_i        (x_pos),
      .y_pos_i        (y_pos),
      .video_active_i (video_active),
      .enable_i       (enable),
      .box_x_o        (box_x),
      .box_y_o        (box_y)
   );

   // dx/dy are only meaningful once the lower-bound compare passes.
   assign dx   = x_pos - box_x;
   assign dy   = y_pos - box_y;
   assign in_x = (x_pos >= box_x) && (dx < BoxSz);
   assign in_y = (y_pos >= box_y) && (dy < BoxSz);

`ifdef VGA_SPRITE_OVERLAY_BORDER_EN
   localparam logic [11:0] EdgeHi = 12'(BOX_SIZE - 2);
   logic on_edge;
   assign on_edge = (dx < 12'd2) || (dx >= EdgeHi) || (dy < 12'd2) || (dy >= EdgeHi);
   assign draw    = in_x && in_y && on_edge;
`else
   assign draw    = in_x && in_y;
`endif

   always_comb begin
      rgb_d = '0;
      if (video_active) begin
         if (enable && draw) begin
            rgb_d = rgb_t'(BOX_RGB);
         end else begin
            rgb_d = '{r: rgb_r_in, g: rgb_g_in, b: rgb_b_in};
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rgb_q <= '0;
         h_q   <= 1'b1;
         v_q   <= 1'b1;
         va_q  <= 1'b0;
      end else begin
         rgb_q <= rgb_d;
         h_q   <= h_pulse_in;
         v_q   <= v_pulse_in;
         va_q  <= video_active;
      end
   end

   assign rgb_r            = rgb_q.r;
   assign rgb_g            = rgb_q.g;
   assign rgb_b            = rgb_q.b;
   assign h_pulse          = h_q;
   assign v_pulse          = v_q;
   assign video_active_out = va_q;

endmodule

// File: doc/vga_sprite_overlay.md
VGA_SPRITE_OVERLAY -- requirements
Module: vga_sprite_overlay

Interface
REQ-001 Parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480: active lines per frame.
REQ-003 Parameter BOX_SIZE, default 32: sprite width and height in pixels.
REQ-004 Parameter STEP, default 2: sprite displacement per frame on each axis, in pixels.
REQ-005 Parameter BOX_RGB, default 24'hFF0000: sprite colour as {R,G,B}.
REQ-006 clk  input  1  pixel clock, the same clock that drives the timing generator and pattern stage.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 x_pos, y_pos  input  12 each  pixel coordinate from the timing generator; (0,0) is the top-left pixel.
REQ-009 video_active  input  1  high while (x_pos,y_pos) is inside the active area.
REQ-010 h_pulse_in, v_pulse_in  input  1 each  horizontal and vertical syncs from the timing generator.
REQ-011 rgb_r_in, rgb_g_in, rgb_b_in  input  8 each  background pixel from the display-pattern stage.
REQ-012 enable  input  1  high means overlay drawn and motion running.
REQ-013 rgb_r, rgb_g, rgb_b  output  8 each  composited pixel, registered.
REQ-014 h_pulse, v_pulse, video_active_out  output  1 each  syncs and active flag, delayed to align with the RGB outputs.

Function
REQ-015 All outputs SHALL be registered with a fixed 1-cycle latency from the inputs.
REQ-016 Syncs and video_active SHALL be delayed by exactly that 1 cycle.
REQ-017 Hit condition: box_x <= x_pos < box_x+BOX_SIZE AND box_y <= y_pos < box_y+BOX_SIZE.
REQ-018 With enable high, video_active high and a hit, the RGB outputs SHALL be BOX_RGB.
REQ-019 With video_active high and no hit, or with enable low, the RGB outputs SHALL equal the registered background inputs.
REQ-020 With video_active low, the RGB outputs SHALL be 0.
REQ-021 frame_tick SHALL pulse for one cycle when video_active=1, x_pos=H_ACTIVE-1 and y_pos=V_ACTIVE-1.
REQ-022 Position SHALL update only on frame_tick with enable=1, so the sprite never moves mid-frame.
REQ-023 Direction FSM, X axis: states RIGHT and LEFT.
 - RIGHT: box_x += STEP; if box_x+STEP >= H_ACTIVE-BOX_SIZE, clamp box_x to H_ACTIVE-BOX_SIZE and go to LEFT.
 - LEFT: box_x -= STEP; if box_x <= STEP, clamp box_x to 0 and go to RIGHT.
REQ-024 Direction FSM, Y axis: states DOWN and UP, using the same rules with V_ACTIVE.
REQ-025 The X and Y axes SHALL update independently on the same tick; a corner hit flips both directions.
REQ-026 Coordinate arithmetic SHALL be 12-bit unsigned with no wrap-around; clamping guarantees box_x <= H_ACTIVE-BOX_SIZE and box_y <= V_ACTIVE-BOX_SIZE at all times.
REQ-027 enable low SHALL freeze position and direction; movement resumes from the frozen state when enable returns high.

Reset
REQ-028 While rst=0, the RGB outputs and video_active_out SHALL be 0, h_pulse and v_pulse SHALL be 1, box_x and box_y SHALL be 0, and the directions SHALL be RIGHT and DOWN.
REQ-029 Reset asserted mid-frame SHALL take effect immediately.
REQ-030 After reset deasserts, the first position update SHALL occur at the next complete frame_tick.

Configuration
REQ-031 Macro VGA_SPRITE_OVERLAY_BORDER_EN: when defined, only a 2-pixel outline of the box (a hit within 2 pixels of any box edge) SHALL take BOX_RGB, and the interior SHALL show the background.
REQ-032 When VGA_SPRITE_OVERLAY_BORDER_EN is undefined, the box SHALL be drawn solid.

Structure
REQ-033 Package vga_pkg SHALL hold H_ACTIVE/V_ACTIVE defaults, the rgb_t typedef (3x8 bits) and the dir_t enum (RIGHT, LEFT, DOWN, UP).
REQ-034 Sub-module vga_sprite_motion SHALL contain the frame_tick detector and both axis FSMs, and SHALL output box_x and box_y.
REQ-035 The top level SHALL contain only the hit compare, the colour mux and the delay registers.

Verification
REQ-036 Reset mid-line -> RGB=0, h_pulse=v_pulse=1 in the same cycle; after release, box is at (0,0).
REQ-037 Frame 0, enable=1, background 0x202020 -> pixel (0,0) = FF0000; (32,0) = 202020; (31,31) = FF0000, each one cycle after the input.
REQ-038 One frame_tick -> box at (2,2); second frame shows (1,1)=background and (2,2)=FF0000.
REQ-039 Preload to box_x=606 moving RIGHT, then one tick -> box_x=608 and direction LEFT; next tick -> box_x=606.
REQ-040 Corner at (608,448) on one tick -> both axes flip; enable=0 for 3 frames -> position unchanged and RGB equals background.
REQ-041 With VGA_SPRITE_OVERLAY_BORDER_EN defined, box at (0,0) -> (1,1)=FF0000 and (10,10)=background.
